// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : input_conditioner
// Purpose  : Multi-channel input front end. Each channel is inverted, synchronised,
//            debounced and turned into level/rise/fall/press outputs.
//            Define INPUT_COND_REPEAT_EN to add auto-repeat pulses on press.
// Revision : 1.0 - initial release
// ============================================================================
module input_conditioner #(
    parameter int                  CHANNELS       = 4,
    parameter int                  SYNC_STAGES    = 2,
    parameter logic [CHANNELS-1:0] INVERT         = {CHANNELS{1'b0}},
    parameter int                  DEBOUNCE_TICKS = 3,
    parameter int                  REPEAT_DELAY   = 8,
    parameter int                  REPEAT_PERIOD  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] din,
    input  logic                tick,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] press
);

    localparam int c_cnt_w = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
    logic [CHANNELS-1:0] sync_s;
    logic [CHANNELS-1:0] level_q;
    logic [CHANNELS-1:0] level_d;
    logic [CHANNELS-1:0] rise_d;
    logic [CHANNELS-1:0] fall_d;
    logic [CHANNELS-1:0] press_d;
    logic [CHANNELS-1:0] rise_q;
    logic [CHANNELS-1:0] fall_q;
    logic [CHANNELS-1:0] press_q;

    if (SYNC_STAGES < 2 || DEBOUNCE_TICKS < 0 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("input_conditioner: illegal parameter combination");
    end

    // Stage 0 sits in the low slice; the last stage is the synchronised sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din ^ INVERT};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    if (DEBOUNCE_TICKS > 0) begin : g_debounce
        localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_TICKS - 1);

        for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
            logic [c_cnt_w-1:0] cnt_q;
            logic               accept;

            assign accept = (sync_s[ch] != level_q[ch]) && tick && (cnt_q == c_cnt_last);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else if (sync_s[ch] == level_q[ch]) begin
                    cnt_q <= '0;
                end else if (tick) begin
                    if (cnt_q == c_cnt_last) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end

            assign level_d[ch] = accept ? sync_s[ch] : level_q[ch];
        end
    end else begin : g_bypass
        assign level_d = sync_s;
    end

    assign rise_d = level_d & ~level_q;
    assign fall_d = ~level_d & level_q;

`ifdef INPUT_COND_REPEAT_EN
    localparam int c_rep_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_rep_w   = (c_rep_max > 1) ? $clog2(c_rep_max) : 1;
    localparam logic [c_rep_w-1:0] c_delay_last  = c_rep_w'(REPEAT_DELAY - 1);
    localparam logic [c_rep_w-1:0] c_period_last = c_rep_w'(REPEAT_PERIOD - 1);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_repeat
        logic [c_rep_w-1:0] rcnt_q;
        logic               phase_q;
        logic               at_limit;

        assign at_limit = (rcnt_q == (phase_q ? c_period_last : c_delay_last));

        // Driven from the next level so a release never fires a late repeat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rcnt_q  <= '0;
                phase_q <= 1'b0;
            end else if (!level_d[ch] || rise_d[ch]) begin
                rcnt_q  <= '0;
                phase_q <= 1'b0;
            end else if (tick) begin
                if (at_limit) begin
                    rcnt_q  <= '0;
                    phase_q <= 1'b1;
                end else begin
                    rcnt_q <= rcnt_q + 1'b1;
                end
            end
        end

        assign press_d[ch] = rise_d[ch] | (level_d[ch] & ~rise_d[ch] & tick & at_limit);
    end
`else
    assign press_d = rise_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            press_q <= '0;
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
    assign press = press_q;

endmodule
`default_nettype wire
